axil_cfg_responder: RTL and testbench
=====================================

Name: axil_cfg_responder

Overview:
- AXI-Lite responder (single slot) that accepts host accesses and converts each into one cfg_bus transaction: drives addr/wdata/wr/rd and waits for ack/rdata.
- Sits between the shell-side AXI-Lite master and the CL register-file agents that answer the cfg bus.
- Provides one-outstanding-access serialisation, read/write round-robin arbitration, and an ack timeout that returns SLVERR.

Parameters:
- TIMEOUT_CYCLES, 256: cycles to wait for cfg_ack before returning SLVERR. Must be ≥1.
- ERR_RDATA, 32'hDEAD_BEEF: rdata returned on a read timeout.

Ports:
- clk_main_a0  in  1  clock
- rst_main_n  in  1  async active-low reset
- s_awaddr/s_awvalid/s_awready  in/in/out  32/1/1  AXI-Lite write address
- s_wdata/s_wstrb/s_wvalid/s_wready  in/in/in/out  32/4/1/1  AXI-Lite write data
- s_bresp/s_bvalid/s_bready  out/out/in  2/1/1  write response
- s_araddr/s_arvalid/s_arready  in/in/out  32/1/1  read address
- s_rdata/s_rresp/s_rvalid/s_rready  out/out/out/in  32/2/1/1  read data
- cfg_addr  out  32  transaction address, held from wr/rd pulse until ack/timeout
- cfg_wdata  out  32  write data, held likewise
- cfg_wr  out  1  one-cycle write strobe
- cfg_rd  out  1  one-cycle read strobe
- cfg_ack  in  1  completion from agent
- cfg_rdata  in  32  read data, valid with cfg_ack

Behaviour:
- Interface: one clock, clk_main_a0. Reset rst_main_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; aw_held, w_held and last_rd cleared.
- States: IDLE, CFG_WR, CFG_RD, WR_RESP, RD_RESP.
- IDLE channel readiness:
  - s_arready = !aw_held && !w_held && !(last_rd && (s_awvalid||s_wvalid)).
  - rd_grant = s_arvalid && s_arready.
  - s_awready = !aw_held && !rd_grant.
  - s_wready = !w_held && !rd_grant.
  - All readies are 0 outside IDLE.
- AW and W may handshake in either order or the same cycle. Each is captured into a holding register with its held flag set.
- When both are held (registered decision), enter CFG_WR the next cycle:
  - If s_wstrb == 4'hF: cfg_wr=1 for exactly that first cycle.
  - Otherwise (partial strobe): no cfg_wr; go directly to WR_RESP with SLVERR (2'b10).
- rd_grant captures s_araddr. The next cycle enters CFG_RD with cfg_rd=1 for one cycle.
- Ack and timeout in CFG_WR/CFG_RD:
  - cfg_ack is sampled every cycle, including the strobe cycle.
  - The timeout counter (width $clog2(TIMEOUT_CYCLES+1)) is cleared on state entry and increments each cycle.
  - Ack in CFG_RD: capture cfg_rdata, set rresp=OKAY.
  - Ack in CFG_WR: set bresp=OKAY.
  - No ack within TIMEOUT_CYCLES cycles: SLVERR. Reads also return ERR_RDATA.
  - Response is valid the cycle after the ack or timeout.
- cfg_ack outside CFG states is ignored; late acks are dropped.
- WR_RESP: s_bvalid held with stable bresp until s_bready. Then go to IDLE, clear held flags, set last_rd=0.
- RD_RESP: s_rvalid held with stable rdata/rresp until s_rready. Then go to IDLE, set last_rd=1.
- Minimum latency: handshake at cycle 0, strobe at 1, ack at 1, valid at 2. Only one access is ever outstanding.
- Reset mid-operation:
  - All state aborts immediately, including any pending cfg transaction and held AW/W.
  - No response is issued for an in-flight access.

Test Plan:
- Write: aw+w (addr 0x10, data 0xA5A5_0001, strb F) at cycle 0, ack at cycle 1 -> cfg_wr=1 with addr 0x10/data 0xA5A5_0001 at cycle 1; bvalid with bresp 0 at cycle 2.
- Read with delay: ar 0x24 at cycle 0, ack at cycle 4 with rdata 0x1234_5678 -> cfg_rd at cycle 1; rvalid with rdata 0x1234_5678/rresp 0 at cycle 5; rready held low 3 cycles -> data stable, no new arready.
- Timeout: read with no ack -> rvalid at cycle 257 with rdata 0xDEAD_BEEF, rresp 2; ack at cycle 260 is ignored, and the next read completes normally.
- Partial strobe: W (strb 4'h3) at cycle 0, AW at cycle 2 -> cfg_wr never asserts; bvalid at cycle 4 with bresp 2.
- Arbitration: arvalid+awvalid+wvalid held continuously from reset -> read served first, then write, then read (alternating); awready/wready are 0 in the read-grant cycle.
- Reset mid-op: deassert rst_main_n while in CFG_WR -> cfg_wr/bvalid/readies are 0 immediately; after release, IDLE with awready=1 and no stale bvalid.

Source files
------------

// File: rtl/axil_cfg_responder.sv
// AXI-Lite slave that turns each host access into a single cfg_bus strobe/ack transaction.
// One access in flight; reads and writes alternate under contention; missing acks time out to SLVERR.
module axil_cfg_responder #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [31:0] cfg_addr,
  output logic [31:0] cfg_wdata,
  output logic        cfg_wr,
  output logic        cfg_rd,
  input  logic        cfg_ack,
  input  logic [31:0] cfg_rdata
);

  localparam int unsigned   CW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]    OKAY     = 2'b00;
  localparam logic [1:0]    SLVERR   = 2'b10;

  typedef enum logic [2:0] {IDLE, CFG_WR, CFG_RD, WR_RESP, RD_RESP} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        run;
  logic        aw_held;
  logic        w_held;
  logic        last_rd;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic [1:0]  resp_q;
  logic [CW-1:0] cnt;

  logic idle;
  logic rd_grant;
  logic aw_hs;
  logic w_hs;
  logic wr_go;
  logic strb_full;
  logic first;
  logic timeout;

  // run keeps every ready low while reset is asserted and for the first cycle after release
  assign idle      = run && (state == IDLE);
  assign s_arready = idle && !aw_held && !w_held && !(last_rd && (s_awvalid || s_wvalid));
  assign rd_grant  = s_arvalid && s_arready;
  assign s_awready = idle && !aw_held && !rd_grant;
  assign s_wready  = idle && !w_held && !rd_grant;
  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;
  assign wr_go     = (aw_held || aw_hs) && (w_held || w_hs);

  assign strb_full = (wstrb_q == 4'hF);
  assign first     = (cnt == '0);
  assign timeout   = (cnt == CNT_LAST);

  assign cfg_wr    = (state == CFG_WR) && first && strb_full;
  assign cfg_rd    = (state == CFG_RD) && first;
  assign cfg_addr  = addr_q;
  assign cfg_wdata = wdata_q;

  assign s_bvalid  = (state == WR_RESP);
  assign s_rvalid  = (state == RD_RESP);
  assign s_bresp   = resp_q;
  assign s_rresp   = resp_q;
  assign s_rdata   = rdata_q;

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (rd_grant)   state_nxt = CFG_RD;
        else if (wr_go) state_nxt = CFG_WR;
      end
      CFG_WR:  if (!strb_full || cfg_ack || timeout) state_nxt = WR_RESP;
      CFG_RD:  if (cfg_ack || timeout)               state_nxt = RD_RESP;
      WR_RESP: if (s_bready)                         state_nxt = IDLE;
      RD_RESP: if (s_rready)                         state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      run     <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      last_rd <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      resp_q  <= OKAY;
      cnt     <= '0;
    end else begin
      run <= 1'b1;

      // counter restarts on every state change, so it reads 0 in the strobe cycle
      if (state != state_nxt)
        cnt <= '0;
      else if (state == CFG_WR || state == CFG_RD)
        cnt <= cnt + 1'b1;

      if (aw_hs) begin
        aw_held <= 1'b1;
        addr_q  <= s_awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
      end
      if (rd_grant)
        addr_q <= s_araddr;

      case (state)
        CFG_WR: begin
          if (!strb_full)   resp_q <= SLVERR;
          else if (cfg_ack) resp_q <= OKAY;
          else if (timeout) resp_q <= SLVERR;
        end
        CFG_RD: begin
          if (cfg_ack) begin
            rdata_q <= cfg_rdata;
            resp_q  <= OKAY;
          end else if (timeout) begin
            rdata_q <= ERR_RDATA;
            resp_q  <= SLVERR;
          end
        end
        WR_RESP: begin
          if (s_bready) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            last_rd <= 1'b0;
          end
        end
        RD_RESP: begin
          if (s_rready) last_rd <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cfg_responder.sv
// Randomised scoreboard bench for axil_cfg_responder with a register-file agent on the cfg bus.
module tb_axil_cfg_responder;

  localparam int TO = 256;
  localparam logic [31:0] DEF = 32'h5A5A_0000;

  typedef struct { int vcyc; logic [31:0] data; logic [1:0] resp; } rsp_t;
  typedef struct { bit wr; logic [31:0] addr; logic [31:0] wdata; } cfg_t;

  logic clk = 1'b0;
  logic rst_main_n;
  logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata, cfg_addr, cfg_wdata, cfg_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  s_bresp, s_rresp;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready, cfg_wr, cfg_rd, cfg_ack;

  axil_cfg_responder dut (
    .clk_main_a0(clk), .rst_main_n(rst_main_n),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd),
    .cfg_ack(cfg_ack), .cfg_rdata(cfg_rdata)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int resp_cnt = 0;
  int agent_delay = 0;
  int stall_left = 0;
  bit agent_busy = 0;
  bit b_prev = 0;
  bit r_prev = 0;

  rsp_t exp_b[$];
  rsp_t exp_r[$];
  cfg_t exp_cfg[$];
  int   exp_order[$];              // 1 = write response, 0 = read response
  logic [31:0] ref_mem   [logic [31:0]];
  logic [31:0] agent_mem [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic budget_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: cycle budget expired before completion (cycle %0d)", name, cyc);
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ DEF);
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // response acceptor: optional stall cycles once a response is presented
  initial begin
    s_bready = 1'b0;
    s_rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (s_bvalid || s_rvalid) begin
        if (stall_left > 0) begin
          stall_left--;
          s_bready = 1'b0;
          s_rready = 1'b0;
        end else begin
          s_bready = 1'b1;
          s_rready = 1'b1;
        end
      end else begin
        s_bready = 1'b0;
        s_rready = 1'b0;
      end
    end
  end

  // cfg-bus register-file agent
  initial begin
    cfg_t c;
    int d;
    logic [31:0] a, wd;
    bit w;
    cfg_ack = 1'b0;
    cfg_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_main_n && (cfg_wr || cfg_rd)) begin
        if (exp_cfg.size() == 0) begin
          check("unexpected_strobe", {30'd0, cfg_wr, cfg_rd}, 32'd0);
        end else begin
          c = exp_cfg.pop_front();
          check("strobe_kind", {31'd0, cfg_wr}, {31'd0, c.wr});
          check("cfg_addr", cfg_addr, c.addr);
          if (c.wr) check("cfg_wdata", cfg_wdata, c.wdata);
        end
        d = agent_delay;
        if (d >= 0) begin
          agent_busy = 1'b1;
          a = cfg_addr;
          wd = cfg_wdata;
          w = cfg_wr;
          if (d > 0) begin
            repeat (d) @(posedge clk);
            #1;
          end
          if (w) agent_mem[a] = wd;
          cfg_rdata = agent_mem.exists(a) ? agent_mem[a] : (a ^ DEF);
          cfg_ack = 1'b1;
          @(posedge clk); #1;
          cfg_ack = 1'b0;
          cfg_rdata = '0;
          agent_busy = 1'b0;
        end
      end
    end
  end

  // response monitor / scoreboard
  initial begin
    int k;
    forever begin
      @(negedge clk);
      if (!rst_main_n) begin
        b_prev = 0;
        r_prev = 0;
      end else begin
        if (s_arvalid && s_arready) begin
          check("grant_awready_low", {31'd0, s_awready}, 32'd0);
          check("grant_wready_low", {31'd0, s_wready}, 32'd0);
        end
        if (s_bvalid) begin
          if (!b_prev) begin
            if (exp_b.size() == 0 || exp_order.size() == 0) begin
              check("no_stale_bvalid", {31'd0, s_bvalid}, 32'd0);
            end else begin
              k = exp_order.pop_front();
              check("resp_order", {30'd0, s_bvalid, s_rvalid}, (k == 1) ? 32'd2 : 32'd1);
              if (exp_b[0].vcyc >= 0) check("b_latency", 32'(cyc), 32'(exp_b[0].vcyc));
            end
          end
          if (exp_b.size() > 0) begin
            check("bresp", {30'd0, s_bresp}, {30'd0, exp_b[0].resp});
            check("b_readies_low", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
            if (s_bready) begin
              void'(exp_b.pop_front());
              resp_cnt++;
            end
          end
        end
        if (s_rvalid) begin
          if (!r_prev) begin
            if (exp_r.size() == 0 || exp_order.size() == 0) begin
              check("no_stale_rvalid", {31'd0, s_rvalid}, 32'd0);
            end else begin
              k = exp_order.pop_front();
              check("resp_order", {30'd0, s_bvalid, s_rvalid}, (k == 1) ? 32'd2 : 32'd1);
              if (exp_r[0].vcyc >= 0) check("r_latency", 32'(cyc), 32'(exp_r[0].vcyc));
            end
          end
          if (exp_r.size() > 0) begin
            check("rdata", s_rdata, exp_r[0].data);
            check("rresp", {30'd0, s_rresp}, {30'd0, exp_r[0].resp});
            check("r_readies_low", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
            if (s_rready) begin
              void'(exp_r.pop_front());
              resp_cnt++;
            end
          end
        end
        b_prev = s_bvalid && !s_bready;
        r_prev = s_rvalid && !s_rready;
      end
    end
  end

  task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                             input int aw_d, input int w_d, input int ack_d, input int stall);
    int t = 0;
    int h = 0;
    bit aw_done = 0;
    bit w_done = 0;
    bit ok;
    rsp_t e;
    agent_delay = ack_d;
    stall_left = stall;
    s_awaddr = a;
    s_wdata = d;
    s_wstrb = st;
    while (!(aw_done && w_done) && t < 100) begin
      @(posedge clk); #1;
      s_awvalid = !aw_done && (t >= aw_d);
      s_wvalid  = !w_done && (t >= w_d);
      @(negedge clk);
      if (s_awvalid && s_awready) begin aw_done = 1; h = cyc; end
      if (s_wvalid && s_wready)   begin w_done = 1;  h = cyc; end
      t++;
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0;
    s_wvalid = 1'b0;
    if (!(aw_done && w_done)) begin
      budget_fail("write_handshake");
      return;
    end
    ok = (st == 4'hF) && (ack_d >= 0) && (ack_d < TO);
    if (st == 4'hF) exp_cfg.push_back('{1'b1, a, d});
    e.data = '0;
    e.resp = ok ? 2'b00 : 2'b10;
    e.vcyc = (st != 4'hF) ? h + 2 : (ok ? h + 2 + ack_d : h + 1 + TO);
    if (ok) ref_mem[a] = d;
    exp_b.push_back(e);
    exp_order.push_back(1);
  endtask

  task automatic issue_read(input logic [31:0] a, input int ar_d, input int ack_d, input int stall);
    int t = 0;
    int h = 0;
    bit done = 0;
    bit ok;
    rsp_t e;
    agent_delay = ack_d;
    stall_left = stall;
    s_araddr = a;
    while (!done && t < 100) begin
      @(posedge clk); #1;
      s_arvalid = (t >= ar_d);
      @(negedge clk);
      if (s_arvalid && s_arready) begin done = 1; h = cyc; end
      t++;
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    if (!done) begin
      budget_fail("read_handshake");
      return;
    end
    ok = (ack_d >= 0) && (ack_d < TO);
    exp_cfg.push_back('{1'b0, a, 32'd0});
    e.data = ok ? ref_rd(a) : 32'hDEAD_BEEF;
    e.resp = ok ? 2'b00 : 2'b10;
    e.vcyc = ok ? h + 2 + ack_d : h + 1 + TO;
    exp_r.push_back(e);
    exp_order.push_back(0);
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while ((exp_b.size() != 0 || exp_r.size() != 0 || agent_busy) && t < 1000) begin
      @(posedge clk);
      t++;
    end
    if (t >= 1000) begin
      budget_fail(name);
      exp_b.delete();
      exp_r.delete();
      exp_order.delete();
      exp_cfg.delete();
    end
  endtask

  initial begin
    int base;
    logic [31:0] a;
    logic [3:0]  st;
    int r, ackd;

    rst_main_n = 1'b0;
    s_awaddr = 32'h30; s_wdata = 32'h0BAD_F00D; s_wstrb = 4'hF;
    s_araddr = 32'h34;
    s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
    ref_mem[32'h24] = 32'h1234_5678;
    agent_mem[32'h24] = 32'h1234_5678;

    // reset state, with all request channels already valid
    repeat (2) @(negedge clk);
    check("rst_awready", {31'd0, s_awready}, 32'd0);
    check("rst_wready", {31'd0, s_wready}, 32'd0);
    check("rst_arready", {31'd0, s_arready}, 32'd0);
    check("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
    check("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
    check("rst_strobes", {30'd0, cfg_wr, cfg_rd}, 32'd0);
    check("rst_cfg_addr", cfg_addr, 32'd0);
    check("rst_cfg_wdata", cfg_wdata, 32'd0);
    check("rst_rdata", s_rdata, 32'd0);
    check("rst_resps", {28'd0, s_bresp, s_rresp}, 32'd0);

    // arbitration: read first, then alternate
    agent_delay = 0;
    stall_left = 0;
    for (int i = 0; i < 2; i++) begin
      exp_order.push_back(0);
      exp_order.push_back(1);
      exp_cfg.push_back('{1'b0, 32'h34, 32'd0});
      exp_cfg.push_back('{1'b1, 32'h30, 32'h0BAD_F00D});
      exp_r.push_back('{-1, ref_rd(32'h34), 2'b00});
      exp_b.push_back('{-1, 32'd0, 2'b00});
    end
    ref_mem[32'h30] = 32'h0BAD_F00D;
    base = resp_cnt;
    @(posedge clk); #1;
    rst_main_n = 1'b1;
    for (int t = 0; t < 300 && resp_cnt < base + 4; t++) @(posedge clk);
    if (resp_cnt < base + 4) budget_fail("arbitration");
    #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    wait_done("arbitration_drain");

    // directed cases
    issue_write(32'h10, 32'hA5A5_0001, 4'hF, 0, 0, 0, 0);
    wait_done("write_min_latency");
    issue_read(32'h24, 0, 3, 3);
    wait_done("read_delayed");
    issue_read(32'h40, 0, 259, 0);
    wait_done("read_timeout");
    issue_read(32'h10, 0, 1, 0);
    wait_done("read_after_timeout");
    issue_write(32'h10, 32'hFFFF_FFFF, 4'h3, 2, 0, 0, 1);
    wait_done("partial_strobe");
    issue_read(32'h10, 1, 0, 0);
    wait_done("read_after_partial");
    issue_write(32'h18, 32'hCAFE_0018, 4'hF, 1, 0, -1, 0);
    wait_done("write_timeout");
    issue_read(32'h18, 0, 2, 2);
    wait_done("read_after_write_timeout");

    // randomised traffic
    for (int n = 0; n < 40; n++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      r = $urandom_range(0, 19);
      ackd = (r == 0) ? -1 : 32'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 0) begin
        st = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
        issue_write(a, $urandom, st, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
                    ackd, 32'($urandom_range(0, 2)));
      end else begin
        if (r == 1) ackd = 300;
        issue_read(a, 32'($urandom_range(0, 2)), ackd, 32'($urandom_range(0, 2)));
      end
      wait_done("random");
    end

    // reset while in CFG_WR: strobe cycle, no ack
    issue_write(32'h20, 32'h1111_2222, 4'hF, 0, 0, -1, 0);
    @(negedge clk);
    #2;
    rst_main_n = 1'b0;
    #1;
    check("midrst_cfg_wr", {31'd0, cfg_wr}, 32'd0);
    check("midrst_bvalid", {31'd0, s_bvalid}, 32'd0);
    check("midrst_readies", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
    exp_b.delete();
    exp_order.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_main_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_awready", {31'd0, s_awready}, 32'd1);
    repeat (20) @(negedge clk);
    check("post_rst_no_bvalid", {31'd0, s_bvalid}, 32'd0);
    issue_read(32'h20, 0, 0, 0);
    wait_done("read_after_reset");

    check("leftover_cfg", 32'(exp_cfg.size()), 32'd0);
    check("leftover_order", 32'(exp_order.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
